// File: rtl/gpio_arbiter.sv
// gpio_arbiter: round-robin arbiter sharing one GPIO slave between two masters,
// with a per-transaction slave timeout and a sticky timeout error flag.
module gpio_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [3:0]  m0_mem_wstrb,
  input  logic [31:0] m0_mem_wdata,
  input  logic [31:0] m0_mem_addr,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [3:0]  m1_mem_wstrb,
  input  logic [31:0] m1_mem_wdata,
  input  logic [31:0] m1_mem_addr,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [3:0]  s_mem_wstrb,
  output logic [31:0] s_mem_wdata,
  output logic [31:0] s_mem_addr,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,
  input  logic        err_clr,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, RELEASE} state_t;
  state_t state, state_nx;
  logic last;
  logic [7:0] cnt;
  logic own, hit, done, req, g1;
  assign own = (state == OWN0) || (state == OWN1);
  assign hit = cnt == 8'(TIMEOUT - 1);
  assign done = own && (s_mem_ready || hit);
  assign req = (state == IDLE) && (m0_mem_valid || m1_mem_valid);
  // m1 wins when alone, or on a tie when m0 was served last
  assign g1 = m1_mem_valid && (!m0_mem_valid || !last);
  assign s_mem_valid = own;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (req) state_nx = g1 ? OWN1 : OWN0;
    else if (done) state_nx = RELEASE;
    else if (state == RELEASE) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      last <= 1'b1;
      cnt <= 8'd0;
      timeout_err <= 1'b0;
      s_mem_instr <= 1'b0;
      s_mem_wstrb <= 4'h0;
      s_mem_wdata <= 32'h0;
      s_mem_addr <= 32'h0;
      m0_mem_ready <= 1'b0;
      m1_mem_ready <= 1'b0;
      m0_mem_rdata <= 32'h0;
      m1_mem_rdata <= 32'h0;
    end else begin
      cnt <= own ? cnt + 8'd1 : 8'd0;
      m0_mem_ready <= done && (state == OWN0);
      m1_mem_ready <= done && (state == OWN1);
      m0_mem_rdata <= (state == OWN0 && s_mem_ready) ? s_mem_rdata : 32'h0;
      m1_mem_rdata <= (state == OWN1 && s_mem_ready) ? s_mem_rdata : 32'h0;
      if (done) last <= state == OWN1;
      if (own && hit && !s_mem_ready) timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      if (req) begin
        s_mem_instr <= g1 ? m1_mem_instr : m0_mem_instr;
        s_mem_wstrb <= g1 ? m1_mem_wstrb : m0_mem_wstrb;
        s_mem_wdata <= g1 ? m1_mem_wdata : m0_mem_wdata;
        s_mem_addr <= g1 ? m1_mem_addr : m0_mem_addr;
      end
    end
endmodule

// File: tb/tb_gpio_arbiter.sv
// tb_gpio_arbiter: directed and random stimulus checked against a transaction-level
// model that predicts grant, slave window, completion cycle and error flag arithmetically.
module tb_gpio_arbiter;
  localparam int T = 16;
  logic clk = 1'b0, resetn = 1'b0;
  logic mv[2], mi[2], mready[2];
  logic [3:0] mws[2];
  logic [31:0] mwd[2], ma[2], mrdata[2];
  logic s_valid, s_instr, s_ready, err_clr, timeout_err;
  logic [3:0] s_wstrb;
  logic [31:0] s_wdata, s_addr, s_rdata;

  gpio_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .resetn(resetn),
    .m0_mem_valid(mv[0]), .m0_mem_instr(mi[0]), .m0_mem_wstrb(mws[0]), .m0_mem_wdata(mwd[0]),
    .m0_mem_addr(ma[0]), .m0_mem_ready(mready[0]), .m0_mem_rdata(mrdata[0]),
    .m1_mem_valid(mv[1]), .m1_mem_instr(mi[1]), .m1_mem_wstrb(mws[1]), .m1_mem_wdata(mwd[1]),
    .m1_mem_addr(ma[1]), .m1_mem_ready(mready[1]), .m1_mem_rdata(mrdata[1]),
    .s_mem_valid(s_valid), .s_mem_instr(s_instr), .s_mem_wstrb(s_wstrb), .s_mem_wdata(s_wdata),
    .s_mem_addr(s_addr), .s_mem_ready(s_ready), .s_mem_rdata(s_rdata),
    .err_clr(err_clr), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0, c = 0;
  int g = 0, rc = 0, o = 0, d = 0, sd_fix = -1;
  bit busy = 0, last_m = 1, err_m = 0, rand_mode = 0, clr_once = 0;
  bit pend[2], want[2];
  logic [31:0] rd_exp, srd_fix;
  logic f_instr;
  logic [3:0] f_wstrb;
  logic [31:0] f_wdata, f_addr;
  logic w_instr[2];
  logic [3:0] w_wstrb[2];
  logic [31:0] w_wdata[2], w_addr[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, obs, exp);
    end
  endtask

  task automatic req(input int x, input logic instr, input logic [3:0] wstrb,
                     input logic [31:0] wdata, input logic [31:0] addr);
    want[x] = 1;
    w_instr[x] = instr;
    w_wstrb[x] = wstrb;
    w_wdata[x] = wdata;
    w_addr[x] = addr;
  endtask

  task automatic clear_model();
    busy = 0; last_m = 1; err_m = 0;
    for (int x = 0; x < 2; x++) begin
      pend[x] = 0; want[x] = 0; mv[x] = 0;
    end
  endtask

  task automatic tick();
    bit win, ec;
    int w;
    @(negedge clk);
    c++;
    win = busy && c >= g + 1 && c <= rc - 1;
    chk("s_mem_valid", {31'h0, s_valid}, {31'h0, win});
    if (win) begin
      chk("s_mem_addr", s_addr, f_addr);
      chk("s_mem_wdata", s_wdata, f_wdata);
      chk("s_mem_wstrb", {28'h0, s_wstrb}, {28'h0, f_wstrb});
      chk("s_mem_instr", {31'h0, s_instr}, {31'h0, f_instr});
    end
    for (int x = 0; x < 2; x++) begin
      bit r;
      r = busy && c == rc && o == x;
      chk($sformatf("m%0d_mem_ready", x), {31'h0, mready[x]}, {31'h0, r});
      chk($sformatf("m%0d_mem_rdata", x), mrdata[x], r ? rd_exp : 32'h0);
    end
    chk("timeout_err", {31'h0, timeout_err}, {31'h0, err_m});
    if (busy && c == rc) begin
      pend[o] = 0; mv[o] = 0; last_m = (o == 1);
    end
    if (rand_mode && win && $urandom_range(7) == 0) mv[o] = 0;
    for (int x = 0; x < 2; x++)
      if (!pend[x] && (want[x] || (rand_mode && $urandom_range(2) == 0))) begin
        pend[x] = 1; mv[x] = 1;
        mi[x] = want[x] ? w_instr[x] : 1'($urandom);
        mws[x] = want[x] ? w_wstrb[x] : 4'($urandom);
        mwd[x] = want[x] ? w_wdata[x] : $urandom;
        ma[x] = want[x] ? w_addr[x] : $urandom;
        want[x] = 0;
      end
    ec = rand_mode ? ($urandom_range(7) == 0) : clr_once;
    clr_once = 0;
    err_clr = ec;
    if (win) begin
      s_ready = (c == g + 1 + d);
      s_rdata = rand_mode ? $urandom : srd_fix;
      if (s_ready) rd_exp = s_rdata;
    end else begin
      s_ready = rand_mode ? 1'($urandom_range(1)) : 1'b0;
      s_rdata = $urandom;
    end
    if (busy && c == rc - 1 && d > T - 1) err_m = 1;
    else if (ec) err_m = 0;
    if ((!busy || c >= rc + 1) && (mv[0] || mv[1])) begin
      w = (mv[0] && mv[1]) ? (last_m ? 0 : 1) : (mv[1] ? 1 : 0);
      busy = 1; g = c; o = w;
      d = sd_fix >= 0 ? sd_fix : $urandom_range(20);
      rc = g + 2 + (d < T - 1 ? d : T - 1);
      rd_exp = 32'h0;
      f_instr = mi[w]; f_wstrb = mws[w]; f_wdata = mwd[w]; f_addr = ma[w];
    end
  endtask

  initial begin
    for (int x = 0; x < 2; x++) begin
      mi[x] = 0; mws[x] = 0; mwd[x] = 0; ma[x] = 0;
    end
    clear_model();
    s_ready = 0; s_rdata = 0; err_clr = 0; srd_fix = 0;
    repeat (2) tick();
    resetn = 1;
    req(0, 1'b0, 4'hF, 32'hA5A5_1234, 32'h1000_0000);
    sd_fix = 2;
    repeat (8) tick();
    req(0, 1'b0, 4'h3, 32'h1111_0000, 32'h2000_0000);
    req(1, 1'b1, 4'h0, 32'h2222_0000, 32'h3000_0000);
    sd_fix = 1;
    repeat (12) tick();
    req(0, 1'b0, 4'h1, 32'h3333_0000, 32'h4000_0000);
    req(1, 1'b0, 4'h2, 32'h4444_0000, 32'h5000_0000);
    repeat (12) tick();
    req(1, 1'b0, 4'h0, 32'h0, 32'h6000_0004);
    sd_fix = 3; srd_fix = 32'hDEAD_BEEF;
    repeat (8) tick();
    req(0, 1'b0, 4'h0, 32'h0, 32'h7000_0000);
    sd_fix = 255;
    repeat (25) tick();
    clr_once = 1;
    repeat (3) tick();
    req(1, 1'b0, 4'h0, 32'h0, 32'h8000_0000);
    sd_fix = 15; srd_fix = 32'h1234_5678;
    repeat (20) tick();
    req(0, 1'b0, 4'hF, 32'hCAFE_0000, 32'h9000_0000);
    sd_fix = 10;
    repeat (4) tick();
    resetn = 0;
    #1;
    chk("rst s_mem_valid", {31'h0, s_valid}, 32'h0);
    chk("rst m0_mem_ready", {31'h0, mready[0]}, 32'h0);
    chk("rst m0_mem_rdata", mrdata[0], 32'h0);
    chk("rst s_mem_addr", s_addr, 32'h0);
    clear_model();
    tick();
    resetn = 1;
    req(1, 1'b1, 4'h0, 32'h0, 32'hA000_0000);
    sd_fix = 1;
    repeat (8) tick();
    rand_mode = 1; sd_fix = -1;
    repeat (2000) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
